tx_uart: RTL and testbench

- 8N1 UART transmitter and companion to the team's UART receiver.
- Takes bytes over a valid/ready handshake into a one-entry holding buffer.
- Serialises each byte on o_Tx as: start bit, 8 data bits LSB first, stop bit. Every bit lasts hold_len clocks, derived from sel_baud and CLK_FREQ.
- Sits on the peripheral bus side of the UART; the receiver's i_Rx on the far end consumes o_Tx.

---
 rtl/tx_uart.sv | 132 +++++++++++++
 tb/tb_tx_uart.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_uart.sv
// 8N1 UART transmitter: one-entry holding buffer behind a valid/ready handshake,
// start bit, 8 data bits LSB first, stop bit; each bit lasts hold_len clocks.
module tx_uart #(
   parameter int unsigned CLK_FREQ = 1000000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] sel_baud,
   input  logic [7:0] i_Data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_Tx,
   output logic       o_busy,
   output logic [1:0] dbg_state
);

   // Handshake: a byte moves on the rising edge where i_valid && o_ready are both
   // high; o_ready is simply "holding buffer empty", and i_Data is ignored otherwise.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  buf_data;
   logic        buf_full;
   logic [7:0]  shift;
   logic [2:0]  bit_idx;
   logic [31:0] hold_reg;
   logic [31:0] cnt;
   logic        load;
   logic        bit_last;

   function automatic logic [31:0] hold_of(input logic [3:0] sel);
      logic [31:0] q;
      case (sel)
         4'b0001: q = 32'(CLK_FREQ / 110);
         4'b0010: q = 32'(CLK_FREQ / 300);
         4'b0011: q = 32'(CLK_FREQ / 600);
         4'b0100: q = 32'(CLK_FREQ / 1200);
         4'b0101: q = 32'(CLK_FREQ / 2400);
         4'b0110: q = 32'(CLK_FREQ / 4800);
         4'b0111: q = 32'(CLK_FREQ / 14400);
         4'b1000: q = 32'(CLK_FREQ / 19200);
         4'b1001: q = 32'(CLK_FREQ / 38400);
         4'b1010: q = 32'(CLK_FREQ / 57600);
         4'b1011: q = 32'(CLK_FREQ / 115200);
         4'b1100: q = 32'(CLK_FREQ / 128000);
         4'b1101: q = 32'(CLK_FREQ / 256000);
         default: q = 32'(CLK_FREQ / 9600);
      endcase
      if (q < 32'd2) q = 32'd2;
      return q;
   endfunction

   assign bit_last = (cnt == hold_reg - 32'd1);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (buf_full) begin
               load      = 1'b1;
               state_nxt = START;
            end
         end
         START: if (bit_last) state_nxt = DATA;
         DATA:  if (bit_last && bit_idx == 3'd7) state_nxt = STOP;
         STOP: begin
            // Chain straight into the next start bit so back-to-back frames have no gap
            if (bit_last) begin
               if (buf_full) begin
                  load      = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state    <= IDLE;
         buf_data <= 8'd0;
         buf_full <= 1'b0;
         shift    <= 8'd0;
         bit_idx  <= 3'd0;
         hold_reg <= 32'd2;
         cnt      <= 32'd0;
         o_Tx     <= 1'b1;
      end else begin
         state <= state_nxt;
         // Line lags the state by one clock, so every bit keeps its full width
         case (state)
            START:   o_Tx <= 1'b0;
            DATA:    o_Tx <= shift[0];
            default: o_Tx <= 1'b1;
         endcase
         if (load) begin
            shift    <= buf_data;
            buf_full <= 1'b0;
            hold_reg <= hold_of(sel_baud);
            cnt      <= 32'd0;
            bit_idx  <= 3'd0;
         end else begin
            if (i_valid && !buf_full) begin
               buf_data <= i_Data;
               buf_full <= 1'b1;
            end
            if (state != IDLE) begin
               cnt <= bit_last ? 32'd0 : cnt + 32'd1;
               if (state == DATA && bit_last) begin
                  shift   <= {1'b0, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end
            end
         end
      end
   end

   assign o_ready   = ~buf_full;
   assign o_busy    = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_tx_uart.sv
// Directed bench for tx_uart: a line monitor decodes frames into got_q, which is
// checked against exp_q filled as bytes are accepted.
module tb_tx_uart;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] sel = 4'd0;
   logic [7:0] data = 8'd0;
   logic       valid = 1'b0;
   logic       ready;
   logic       tx;
   logic       busy;
   logic [1:0] dbg;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int acc_cyc = 0;

   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];
   int         hold_q[$];

   tx_uart #(.CLK_FREQ(1000000)) dut (
      .i_clk(clk), .i_rst(rst), .sel_baud(sel), .i_Data(data), .i_valid(valid),
      .o_ready(ready), .o_Tx(tx), .o_busy(busy), .dbg_state(dbg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line monitor: samples each bit at its centre; word = {start_ok, stop, data}
   int         mon_h = 104;
   int         mon_cyc = 0;
   int         mon_k = 0;
   bit         mon_active = 0;
   logic       mon_prev = 1'b1;
   logic [9:0] mon_word = '0;

   always @(negedge clk) begin
      if (!rst) begin
         mon_active = 0;
      end else if (!mon_active) begin
         if (mon_prev && !tx) begin
            mon_active = 1;
            mon_cyc = 0;
            mon_word = '0;
            mon_h = 104;
            if (hold_q.size() > 0) mon_h = hold_q.pop_front();
         end
      end else begin
         mon_cyc++;
         if (mon_cyc % mon_h == mon_h / 2) begin
            mon_k = mon_cyc / mon_h;
            if (mon_k == 0) mon_word[9] = ~tx;
            else if (mon_k <= 8) mon_word[mon_k-1] = tx;
            else begin
               mon_word[8] = tx;
               got_q.push_back(mon_word);
               mon_active = 0;
            end
         end
      end
      mon_prev = tx;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input int h);
      int g = 0;
      while (!ready && g < 30000) begin
         @(negedge clk);
         g++;
      end
      if (!ready) chk("send_ready", 32'(ready), 32'd1);
      data = b;
      valid = 1'b1;
      @(posedge clk);
      exp_q.push_back({2'b11, b});
      hold_q.push_back(h);
      @(negedge clk);
      valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_idle(output int end_c);
      int g = 0;
      @(negedge clk);
      while (busy && g < 30000) begin
         @(negedge clk);
         g++;
      end
      end_c = cyc;
   endtask

   task automatic check_frame(input string tag);
      int g = 0;
      logic [9:0] e;
      while (got_q.size() == 0 && g < 30000) begin
         @(negedge clk);
         g++;
      end
      chk({tag, "_present"}, 32'(got_q.size() > 0), 32'd1);
      if (got_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(tag, 32'(got_q.pop_front()), 32'(e));
      end
   endtask

   initial begin
      int e_c;
      int a0;
      int rise;
      int lows;
      int g;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_state", 32'(dbg), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 0xA5 at 9600: latency, bit widths, 1040-clock busy window
      sel = 4'b0000;
      data = 8'hA5;
      valid = 1'b1;
      @(posedge clk);
      exp_q.push_back({2'b11, 8'hA5});
      hold_q.push_back(104);
      @(negedge clk);
      valid = 1'b0;
      acc_cyc = cyc;
      chk("a5_ready_drop", 32'(ready), 32'd0);
      chk("a5_tx_n", 32'(tx), 32'd1);
      @(negedge clk);
      chk("a5_ready_rise", 32'(ready), 32'd1);
      chk("a5_tx_n1", 32'(tx), 32'd1);
      chk("a5_busy_n1", 32'(busy), 32'd1);
      @(negedge clk);
      chk("a5_tx_start", 32'(tx), 32'd0);
      wait_idle(e_c);
      chk("a5_busy_len", 32'(e_c - acc_cyc), 32'd1041);
      check_frame("a5_frame");

      // 0x00 then 0xFF with valid held high: contiguous 2080 clocks
      repeat (5) @(negedge clk);
      data = 8'h00;
      valid = 1'b1;
      @(posedge clk);
      exp_q.push_back({2'b11, 8'h00});
      hold_q.push_back(104);
      @(negedge clk);
      acc_cyc = cyc;
      chk("b2b_ready_drop", 32'(ready), 32'd0);
      data = 8'hFF;
      @(negedge clk);
      chk("b2b_ready_rise", 32'(ready), 32'd1);
      @(posedge clk);
      exp_q.push_back({2'b11, 8'hFF});
      hold_q.push_back(104);
      @(negedge clk);
      valid = 1'b0;
      chk("b2b_ready_hold", 32'(ready), 32'd0);
      g = 0;
      while (!ready && g < 5000) begin
         @(negedge clk);
         g++;
      end
      rise = cyc;
      chk("b2b_ready_reload", 32'(rise - acc_cyc), 32'd1041);
      wait_idle(e_c);
      chk("b2b_busy_len", 32'(e_c - acc_cyc), 32'd2081);
      check_frame("b2b_frame0");
      check_frame("b2b_frame1");

      // 256000 baud: hold_len 3, 30-clock frame
      repeat (5) @(negedge clk);
      sel = 4'b1101;
      send(8'h3C, 3);
      wait_idle(e_c);
      chk("fast_busy_len", 32'(e_c - acc_cyc), 32'd31);
      check_frame("fast_frame");

      // Baud change mid-frame applies only to the next frame
      repeat (5) @(negedge clk);
      sel = 4'b0000;
      send(8'h55, 104);
      a0 = acc_cyc;
      repeat (300) @(negedge clk);
      sel = 4'b1011;
      send(8'h96, 8);
      wait_idle(e_c);
      chk("baud_chg_len", 32'(e_c - a0), 32'd1121);
      check_frame("baud_chg_f0");
      check_frame("baud_chg_f1");

      // Asynchronous reset mid-DATA aborts the frame
      repeat (5) @(negedge clk);
      sel = 4'b0000;
      send(8'h33, 104);
      repeat (400) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_tx", 32'(tx), 32'd1);
      chk("arst_ready", 32'(ready), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      hold_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      lows = 0;
      repeat (300) begin
         @(negedge clk);
         if (!tx) lows++;
      end
      chk("arst_no_residual", 32'(lows), 32'd0);
      chk("arst_idle", 32'(busy), 32'd0);
      chk("arst_no_frame", 32'(got_q.size()), 32'd0);

      // valid pulses while the buffer is full are ignored
      send(8'h81, 104);
      send(8'h42, 104);
      for (int i = 0; i < 5; i++) begin
         repeat (50) @(negedge clk);
         chk("ign_ready_low", 32'(ready), 32'd0);
         data = 8'hEE;
         valid = 1'b1;
         @(negedge clk);
         valid = 1'b0;
      end
      wait_idle(e_c);
      check_frame("ign_f0");
      check_frame("ign_f1");
      repeat (1200) @(negedge clk);
      chk("ign_no_extra", 32'(got_q.size()), 32'd0);
      chk("exp_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
